hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Stall/forward controller for the 5-stage MIPS pipeline. Consumes the per-instruction Tuse/Tnew
//  codes from the T generator, tracks in-flight writers in E/M/W, and drives the D-stage stall,
//  the E bubble insertion, and the D- and E-stage forwarding-mux selects.
//  Sits beside the decoder in D; its outputs drive the PC/IF-ID enables and the operand bypass muxes.
// PARAMETERS
//  RA_W    5   register-address width
//  CNT_W   16  width of the stall performance counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active-low
//  hold           in   1      global freeze (external busy): scoreboard holds, no stall counted
//  d_valid        in   1      D holds a real instruction (0 = bubble)
//  d_rs, d_rt     in   RA_W   source register addresses of the D instruction
//  d_tuse_rs      in   2      Tuse of rs (3 = not read)
//  d_tuse_rt      in   2      Tuse of rt (3 = not read)
//  d_we           in   1      D instruction writes a GPR
//  d_dst          in   RA_W   destination register of the D instruction
//  d_tnew         in   2      Tnew of the D instruction (value when it is in E)
//  stall          out  1      freeze PC and IF/ID, bubble into E
//  fwd_d_rs_sel   out  2      D-stage rs bypass: 0 = RF, 1 = W, 2 = M, 3 = E
//  fwd_d_rt_sel   out  2      same, for rt
//  fwd_e_rs_sel   out  2      E-stage rs bypass: 0 = pipeline reg, 1 = W, 2 = M
//  fwd_e_rt_sel   out  2      same, for rt
//  stall_cnt      out  CNT_W  number of cycles with stall=1 && !hold, saturating
// BEHAVIOUR
//  State: records E, M, W = {v, dst[RA_W], tnew[2]}; E also holds rs/rt/tuse of its instruction.
//  A record with dst == 0 is never treated as a writer.
//  Reset (rst_n low, async): all v = 0, tnew = 0, stall_cnt = 0.
//  Hence stall = 0 and every fwd_* = 0 during and after reset until a writer enters.
//  Advance on posedge when !hold:
//    W <= M; M <= E with tnew = sat_dec(E.tnew), saturating at 0.
//    E <= stall ? bubble (v = 0) : {d_valid & d_we, d_dst, d_tnew, d_rs, d_rt}.
//  hold = 1: E/M/W and stall_cnt keep their values. hold has priority over stall.
//  Stall (combinational): for src in {rs, rt} with tuse != 3, d_valid, and addr != 0:
//    - Stall if E.v && E.dst == addr && E.tnew > tuse.
//    - Stall if M.v && M.dst == addr && M.tnew > tuse.
//    stall = OR over both sources. W never causes a stall.
//  D forward select: nearest stage whose dst matches and whose tnew == 0.
//    Priority E (3) > M (2) > W (1); otherwise 0.
//    A younger match with tnew > 0 masks older matches, so the select is 0 and stall covers it.
//  E forward select: same rule against the M and W records using E's stored rs/rt.
//    Priority M (2) > W (1); otherwise 0.
//  addr 0 always forces sel = 0.
//  stall_cnt: +1 on each posedge with stall && !hold; sticks at all-ones.
//  Outputs depend only on the current records and D inputs; there is no extra latency.
// TESTING
//  1. lw $8 into E (tnew 2), then D = addu $9,$8,$1 (Tuse 1).
//     -> stall = 1 for 1 cycle.
//     -> When addu reaches E, lw is in W: fwd_e_rs_sel = 1.
//  2. lw $8, then D = beq $8,$0 (Tuse 0).
//     -> stall = 1 for 2 cycles.
//     -> Then fwd_d_rs_sel = 1 (W), stall = 0.
//  3. lui $8 in E (tnew 0), D = beq $8,$8.
//     -> stall = 0, fwd_d_rs_sel = fwd_d_rt_sel = 3.
//  4. E = addu $0,... (dst 0), D = beq $0,$0.
//     -> stall = 0, all selects 0.
//  5. Set up the stall of scenario 1 with hold = 1 for 3 cycles.
//     -> Records unchanged, stall_cnt unchanged.
//     -> After release, the stall resolves exactly as in scenario 1.
//  6. Assert rst_n = 0 mid-stall with stall_cnt = 5.
//     -> stall and every fwd_* are 0 immediately, stall_cnt = 0.
//     -> After release, the first D instruction issues without stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : D-stage stall / bypass controller for a 5-stage MIPS pipe
// Tracks in-flight writers in E/M/W by Tuse/Tnew and drives stall + fwd selects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              d_valid,
   input  logic [RA_W-1:0]   d_rs,
   input  logic [RA_W-1:0]   d_rt,
   input  logic [1:0]        d_tuse_rs,
   input  logic [1:0]        d_tuse_rt,
   input  logic              d_we,
   input  logic [RA_W-1:0]   d_dst,
   input  logic [1:0]        d_tnew,
   output logic              stall,
   output logic [1:0]        fwd_d_rs_sel,
   output logic [1:0]        fwd_d_rt_sel,
   output logic [1:0]        fwd_e_rs_sel,
   output logic [1:0]        fwd_e_rt_sel,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] C_TUSE_NONE = 2'd3;

   logic              e_v_q, e_v_d, m_v_q, m_v_d, w_v_q, w_v_d;
   logic [RA_W-1:0]   e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
   logic [1:0]        e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
   logic [RA_W-1:0]   e_rs_q, e_rs_d, e_rt_q, e_rt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              e_wr, m_wr, w_wr;
   logic [RA_W-1:0]   d_addr [2];
   logic [1:0]        d_tuse [2];
   logic [RA_W-1:0]   e_addr [2];
   logic [1:0]        d_sel  [2];
   logic [1:0]        e_sel  [2];
   logic              stall_c;

   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // Register 0 is hard-wired, so a record targeting it never produces a value.
   assign e_wr = e_v_q && (e_dst_q != '0);
   assign m_wr = m_v_q && (m_dst_q != '0);
   assign w_wr = w_v_q && (w_dst_q != '0);

   assign d_addr[0] = d_rs;
   assign d_addr[1] = d_rt;
   assign d_tuse[0] = d_tuse_rs;
   assign d_tuse[1] = d_tuse_rt;
   assign e_addr[0] = e_rs_q;
   assign e_addr[1] = e_rt_q;

   // The nearest matching writer decides: if it is not ready yet it masks older ones.
   always_comb begin
      stall_c = 1'b0;
      for (int s = 0; s < 2; s++) begin
         d_sel[s] = 2'd0;
         e_sel[s] = 2'd0;
         if (d_addr[s] != '0) begin
            if (e_wr && (e_dst_q == d_addr[s]))
               d_sel[s] = (e_tnew_q == 2'd0) ? 2'd3 : 2'd0;
            else if (m_wr && (m_dst_q == d_addr[s]))
               d_sel[s] = (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
            else if (w_wr && (w_dst_q == d_addr[s]))
               d_sel[s] = (w_tnew_q == 2'd0) ? 2'd1 : 2'd0;
            if (d_valid && (d_tuse[s] != C_TUSE_NONE)) begin
               if (e_wr && (e_dst_q == d_addr[s]) && (e_tnew_q > d_tuse[s])) stall_c = 1'b1;
               if (m_wr && (m_dst_q == d_addr[s]) && (m_tnew_q > d_tuse[s])) stall_c = 1'b1;
            end
         end
         if (e_addr[s] != '0) begin
            if (m_wr && (m_dst_q == e_addr[s]))
               e_sel[s] = (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
            else if (w_wr && (w_dst_q == e_addr[s]))
               e_sel[s] = (w_tnew_q == 2'd0) ? 2'd1 : 2'd0;
         end
      end
   end

   assign stall        = stall_c;
   assign fwd_d_rs_sel = d_sel[0];
   assign fwd_d_rt_sel = d_sel[1];
   assign fwd_e_rs_sel = e_sel[0];
   assign fwd_e_rt_sel = e_sel[1];
   assign stall_cnt    = cnt_q;

   // Tnew keeps counting down into W so a load is ready by the time it retires.
   always_comb begin
      w_v_d    = m_v_q;
      w_dst_d  = m_dst_q;
      w_tnew_d = sat_dec(m_tnew_q);
      m_v_d    = e_v_q;
      m_dst_d  = e_dst_q;
      m_tnew_d = sat_dec(e_tnew_q);
      if (stall_c) begin
         e_v_d    = 1'b0;
         e_dst_d  = '0;
         e_tnew_d = 2'd0;
         e_rs_d   = '0;
         e_rt_d   = '0;
      end else begin
         e_v_d    = d_valid & d_we;
         e_dst_d  = d_dst;
         e_tnew_d = d_tnew;
         e_rs_d   = d_rs;
         e_rt_d   = d_rt;
      end
      cnt_d = cnt_q;
      if (stall_c && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_v_q    <= 1'b0;
         e_dst_q  <= '0;
         e_tnew_q <= 2'd0;
         e_rs_q   <= '0;
         e_rt_q   <= '0;
         m_v_q    <= 1'b0;
         m_dst_q  <= '0;
         m_tnew_q <= 2'd0;
         w_v_q    <= 1'b0;
         w_dst_q  <= '0;
         w_tnew_q <= 2'd0;
         cnt_q    <= '0;
      end else if (!hold) begin
         e_v_q    <= e_v_d;
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         m_v_q    <= m_v_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         w_v_q    <= w_v_d;
         w_dst_q  <= w_dst_d;
         w_tnew_q <= w_tnew_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : directed-vector bench for hazard_scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

   localparam int RA_W  = 5;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             hold;
   logic             d_valid;
   logic [RA_W-1:0]  d_rs, d_rt, d_dst;
   logic [1:0]       d_tuse_rs, d_tuse_rt, d_tnew;
   logic             d_we;
   logic             stall;
   logic [1:0]       fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;
   logic [CNT_W-1:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   hazard_scoreboard #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hold         (hold),
      .d_valid      (d_valid),
      .d_rs         (d_rs),
      .d_rt         (d_rt),
      .d_tuse_rs    (d_tuse_rs),
      .d_tuse_rt    (d_tuse_rt),
      .d_we         (d_we),
      .d_dst        (d_dst),
      .d_tnew       (d_tnew),
      .stall        (stall),
      .fwd_d_rs_sel (fwd_d_rs_sel),
      .fwd_d_rt_sel (fwd_d_rt_sel),
      .fwd_e_rs_sel (fwd_e_rs_sel),
      .fwd_e_rt_sel (fwd_e_rt_sel),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_d(input logic v, input logic we, input int dst, input int tnew,
                        input int rs, input int tuse_rs, input int rt, input int tuse_rt);
      d_valid   = v;
      d_we      = we;
      d_dst     = RA_W'(dst);
      d_tnew    = 2'(tnew);
      d_rs      = RA_W'(rs);
      d_tuse_rs = 2'(tuse_rs);
      d_rt      = RA_W'(rt);
      d_tuse_rt = 2'(tuse_rt);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      set_d(0, 0, 0, 0, 0, 3, 0, 3);
      repeat (3) step();
   endtask

   task automatic issue_lw8();
      set_d(1, 1, 8, 2, 29, 1, 0, 3);
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      hold  = 1'b0;
      set_d(0, 0, 0, 0, 0, 3, 0, 3);
      #1;
      check("rst_stall", stall, 0);
      check("rst_fwd_d_rs", fwd_d_rs_sel, 0);
      check("rst_fwd_e_rs", fwd_e_rs_sel, 0);
      check("rst_cnt", stall_cnt, 0);
      #10 rst_n = 1'b1;
      step();

      // lw $8 ; addu $9,$8,$1 -> one stall, then E-stage forward from W
      issue_lw8();
      set_d(1, 1, 9, 1, 8, 1, 1, 1);
      check("s1_stall", stall, 1);
      check("s1_fwd_d_rs_masked", fwd_d_rs_sel, 0);
      step();
      check("s1_stall_clear", stall, 0);
      check("s1_cnt", stall_cnt, 1);
      step();
      set_d(0, 0, 0, 0, 0, 3, 0, 3);
      check("s1_fwd_e_rs", fwd_e_rs_sel, 1);
      check("s1_fwd_e_rt", fwd_e_rt_sel, 0);

      // lw $8 ; beq $8,$0 -> two stalls, then D forward from W
      flush();
      issue_lw8();
      set_d(1, 0, 0, 0, 8, 0, 0, 0);
      check("s2_stall1", stall, 1);
      step();
      check("s2_stall2", stall, 1);
      step();
      check("s2_stall_clear", stall, 0);
      check("s2_fwd_d_rs", fwd_d_rs_sel, 1);
      check("s2_fwd_d_rt_zero", fwd_d_rt_sel, 0);
      check("s2_cnt", stall_cnt, 3);

      // lui $8 in E ; beq $8,$8 -> forward from E on both operands
      flush();
      set_d(1, 1, 8, 0, 0, 3, 0, 3);
      step();
      set_d(1, 0, 0, 0, 8, 0, 8, 0);
      check("s3_stall", stall, 0);
      check("s3_fwd_d_rs", fwd_d_rs_sel, 3);
      check("s3_fwd_d_rt", fwd_d_rt_sel, 3);

      // Younger unready $8 writer masks older ready one
      set_d(1, 1, 8, 1, 0, 3, 0, 3);
      step();
      set_d(1, 1, 9, 1, 8, 1, 8, 1);
      check("mask_stall", stall, 0);
      check("mask_fwd_d_rs", fwd_d_rs_sel, 0);
      set_d(0, 0, 0, 0, 0, 3, 0, 3);
      step();
      set_d(1, 0, 0, 0, 8, 0, 0, 3);
      check("mask_fwd_d_rs_m", fwd_d_rs_sel, 2);
      check("mask_stall_m", stall, 0);

      // Writer to $0 is never a hazard
      flush();
      set_d(1, 1, 0, 1, 1, 1, 2, 1);
      step();
      set_d(1, 0, 0, 0, 0, 0, 0, 0);
      check("s4_stall", stall, 0);
      check("s4_fwd_d_rs", fwd_d_rs_sel, 0);
      check("s4_fwd_d_rt", fwd_d_rt_sel, 0);

      // Scenario 1 stall frozen by hold for three cycles
      flush();
      issue_lw8();
      hold = 1'b1;
      set_d(1, 1, 9, 1, 8, 1, 1, 1);
      repeat (3) step();
      check("s5_hold_stall", stall, 1);
      check("s5_hold_cnt", stall_cnt, 3);
      hold = 1'b0;
      #1;
      check("s5_rel_stall", stall, 1);
      step();
      check("s5_stall_clear", stall, 0);
      check("s5_cnt", stall_cnt, 4);
      step();
      set_d(0, 0, 0, 0, 0, 3, 0, 3);
      check("s5_fwd_e_rs", fwd_e_rs_sel, 1);

      // Asynchronous reset in the middle of a stall
      flush();
      issue_lw8();
      set_d(1, 0, 0, 0, 8, 0, 0, 0);
      step();
      check("s6_pre_stall", stall, 1);
      check("s6_pre_cnt", stall_cnt, 5);
      rst_n = 1'b0;
      #1;
      check("s6_rst_stall", stall, 0);
      check("s6_rst_cnt", stall_cnt, 0);
      check("s6_rst_fwd_d_rs", fwd_d_rs_sel, 0);
      check("s6_rst_fwd_e_rs", fwd_e_rs_sel, 0);
      check("s6_rst_fwd_e_rt", fwd_e_rt_sel, 0);
      #1 rst_n = 1'b1;
      set_d(1, 1, 9, 1, 8, 1, 1, 1);
      check("s6_post_stall", stall, 0);
      step();
      check("s6_post_cnt", stall_cnt, 0);

      // Counter saturates at all-ones (10 stalls into a 3-bit counter)
      for (int i = 0; i < 5; i++) begin
         flush();
         issue_lw8();
         set_d(1, 0, 0, 0, 8, 0, 0, 0);
         repeat (2) step();
      end
      check("sat_cnt", stall_cnt, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
